// File: rtl/change_dispenser.sv
// change_dispenser: pays out a credit balance as dollar and quarter coins.
// A rising edge on refund_req (seen in IDLE only) latches balance. Coins are
// then ejected largest-first, one pulse at a time, each confirmed by the
// hopper exit sensor. A missing confirmation parks the machine in FAULT until
// fault_clr is raised; payout then resumes from the amount still owed.
// Optional feature macro: COIN_INVENTORY_EN (per-coin stock counters, reload,
// low-stock flag; an empty coin type is skipped).
module change_dispenser #(
   parameter int PULSE_W     = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        refund_req,
   input  logic [11:0] balance,
   input  logic        coin_sensed,
   input  logic        fault_clr,
`ifdef COIN_INVENTORY_EN
   input  logic        reload,
   output logic [7:0]  dollar_cnt,
   output logic [7:0]  quarter_cnt,
   output logic        low_coin,
`endif
   output logic        eject_dollar,
   output logic        eject_quarter,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [11:0] remaining,
   output logic [11:0] paid_total
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      EJECT    = 3'd2,
      WAIT_ACK = 3'd3,
      DONE     = 3'd4,
      FAULT    = 3'd5
   } state_t;

   localparam logic [7:0]  PULSE_LAST = 8'(PULSE_W - 1);
   localparam logic [7:0]  ACK_LAST   = 8'(ACK_TIMEOUT - 1);
   localparam logic [11:0] DOLLAR_C   = 12'd100;
   localparam logic [11:0] QUARTER_C  = 12'd25;

   state_t      state_r, state_nxt_s;
   logic        sel_dollar_r, sel_dollar_nxt_s;  // coin type of the current eject
   logic [7:0]  cnt_r, cnt_nxt_s;                // pulse width / ack timeout counter
   logic [11:0] remaining_r, remaining_nxt_s;
   logic [11:0] paid_r, paid_nxt_s;
   logic        req_d_r;
   logic        req_edge_s;
   logic [11:0] coin_val_s;
   logic        dollar_ok_s, quarter_ok_s;

   logic        eject_dollar_r, eject_quarter_r, busy_r, done_r, fault_r;

`ifdef COIN_INVENTORY_EN
   logic [7:0]  dollar_cnt_r, dollar_cnt_nxt_s;
   logic [7:0]  quarter_cnt_r, quarter_cnt_nxt_s;
   logic        low_coin_r;

   assign dollar_ok_s  = (dollar_cnt_r != 8'd0);
   assign quarter_ok_s = (quarter_cnt_r != 8'd0);
`else
   assign dollar_ok_s  = 1'b1;
   assign quarter_ok_s = 1'b1;
`endif

   assign req_edge_s = refund_req & ~req_d_r;
   assign coin_val_s = sel_dollar_r ? DOLLAR_C : QUARTER_C;

   // Next-state, counter and payout arithmetic
   always_comb begin
      state_nxt_s      = state_r;
      sel_dollar_nxt_s = sel_dollar_r;
      cnt_nxt_s        = cnt_r;
      remaining_nxt_s  = remaining_r;
      paid_nxt_s       = paid_r;
`ifdef COIN_INVENTORY_EN
      dollar_cnt_nxt_s  = dollar_cnt_r;
      quarter_cnt_nxt_s = quarter_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (req_edge_s) begin
               remaining_nxt_s = balance;
               paid_nxt_s      = 12'd0;
               state_nxt_s     = SELECT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SELECT: begin
            cnt_nxt_s = 8'd0;
            if ((remaining_r >= DOLLAR_C) && dollar_ok_s) begin
               sel_dollar_nxt_s = 1'b1;
               state_nxt_s      = EJECT;
            end else if ((remaining_r >= QUARTER_C) && quarter_ok_s) begin
               sel_dollar_nxt_s = 1'b0;
               state_nxt_s      = EJECT;
            end else if (remaining_r >= QUARTER_C) begin
               state_nxt_s = FAULT;
            end else begin
               state_nxt_s = DONE;
            end
         end
         EJECT: begin
            // coin_sensed is deliberately not looked at while the hopper is driven
            if (cnt_r == PULSE_LAST) begin
               cnt_nxt_s   = 8'd0;
               state_nxt_s = WAIT_ACK;
            end else begin
               cnt_nxt_s = cnt_r + 8'd1;
            end
         end
         WAIT_ACK: begin
            if (coin_sensed) begin
               state_nxt_s = SELECT;
               // Guard keeps remaining from wrapping below zero
               if (remaining_r >= coin_val_s) begin
                  remaining_nxt_s = remaining_r - coin_val_s;
                  paid_nxt_s      = paid_r + coin_val_s;
`ifdef COIN_INVENTORY_EN
                  if (sel_dollar_r && (dollar_cnt_r != 8'd0)) begin
                     dollar_cnt_nxt_s = dollar_cnt_r - 8'd1;
                  end else if (!sel_dollar_r && (quarter_cnt_r != 8'd0)) begin
                     quarter_cnt_nxt_s = quarter_cnt_r - 8'd1;
                  end else begin
                     dollar_cnt_nxt_s = dollar_cnt_r;
                  end
`endif
               end else begin
                  remaining_nxt_s = remaining_r;
               end
            end else if (cnt_r == ACK_LAST) begin
               state_nxt_s = FAULT;
            end else begin
               cnt_nxt_s = cnt_r + 8'd1;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         FAULT: begin
            if (fault_clr) begin
               state_nxt_s = SELECT;
            end else begin
               state_nxt_s = FAULT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
`ifdef COIN_INVENTORY_EN
      // Restocking is only honoured while no payout is in progress
      if (reload && (state_r == IDLE)) begin
         dollar_cnt_nxt_s  = 8'd200;
         quarter_cnt_nxt_s = 8'd200;
      end else begin
         dollar_cnt_nxt_s = dollar_cnt_nxt_s;
      end
`endif
   end

   // State, counter and payout bookkeeping registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         sel_dollar_r <= 1'b0;
         cnt_r        <= 8'd0;
         remaining_r  <= 12'd0;
         paid_r       <= 12'd0;
         req_d_r      <= 1'b0;
`ifdef COIN_INVENTORY_EN
         dollar_cnt_r  <= 8'd0;
         quarter_cnt_r <= 8'd0;
`endif
      end else begin
         state_r      <= state_nxt_s;
         sel_dollar_r <= sel_dollar_nxt_s;
         cnt_r        <= cnt_nxt_s;
         remaining_r  <= remaining_nxt_s;
         paid_r       <= paid_nxt_s;
         req_d_r      <= refund_req;
`ifdef COIN_INVENTORY_EN
         dollar_cnt_r  <= dollar_cnt_nxt_s;
         quarter_cnt_r <= quarter_cnt_nxt_s;
`endif
      end
   end

   // Status and hopper drive outputs, registered from the next state so they align with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eject_dollar_r  <= 1'b0;
         eject_quarter_r <= 1'b0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         fault_r         <= 1'b0;
`ifdef COIN_INVENTORY_EN
         low_coin_r      <= 1'b1;
`endif
      end else begin
         eject_dollar_r  <= (state_nxt_s == EJECT) &&  sel_dollar_nxt_s;
         eject_quarter_r <= (state_nxt_s == EJECT) && !sel_dollar_nxt_s;
         busy_r          <= (state_nxt_s != IDLE);
         done_r          <= (state_nxt_s == DONE);
         fault_r         <= (state_nxt_s == FAULT);
`ifdef COIN_INVENTORY_EN
         low_coin_r      <= (dollar_cnt_nxt_s < 8'd10) || (quarter_cnt_nxt_s < 8'd10);
`endif
      end
   end

   assign eject_dollar  = eject_dollar_r;
   assign eject_quarter = eject_quarter_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign fault         = fault_r;
   assign remaining     = remaining_r;
   assign paid_total    = paid_r;
`ifdef COIN_INVENTORY_EN
   assign dollar_cnt    = dollar_cnt_r;
   assign quarter_cnt   = quarter_cnt_r;
   assign low_coin      = low_coin_r;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser. Stimulus pushes the expected hopper
// pulses and completion/fault records; a negedge monitor pops and compares
// each event the DUT produces. A hopper model acknowledges each pulse.
module tb_change_dispenser;
   localparam int PW = 4;
   localparam int AT = 255;
   localparam int K_D = 0, K_Q = 1, K_DONE = 2, K_FAULT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        refund_req = 1'b0;
   logic [11:0] balance = 12'd0;
   logic        coin_sensed = 1'b0;
   logic        fault_clr = 1'b0;
   logic        eject_dollar, eject_quarter, busy, done, fault;
   logic [11:0] remaining, paid_total;
`ifdef COIN_INVENTORY_EN
   logic        reload = 1'b0;
   logic [7:0]  dollar_cnt, quarter_cnt;
   logic        low_coin;
`endif

   typedef struct { int kind; int a; int b; int c; } ev_t;
   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   bit  ack_en = 1'b0;

   change_dispenser #(.PULSE_W(PW), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .reset(reset), .refund_req(refund_req), .balance(balance),
      .coin_sensed(coin_sensed), .fault_clr(fault_clr),
`ifdef COIN_INVENTORY_EN
      .reload(reload), .dollar_cnt(dollar_cnt), .quarter_cnt(quarter_cnt), .low_coin(low_coin),
`endif
      .eject_dollar(eject_dollar), .eject_quarter(eject_quarter), .busy(busy),
      .done(done), .fault(fault), .remaining(remaining), .paid_total(paid_total)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic ev_t mk(input int k, input int a, input int b, input int c);
      ev_t e;
      e.kind = k; e.a = a; e.b = b; e.c = c;
      return e;
   endfunction

   task automatic match(input ev_t got);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d a=%0d b=%0d c=%0d", got.kind, got.a, got.b, got.c);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != got.kind || e.a != got.a || e.b != got.b || e.c != got.c) begin
            failures++;
            $display("FAIL event actual(kind=%0d a=%0d b=%0d c=%0d) required(kind=%0d a=%0d b=%0d c=%0d)",
                     got.kind, got.a, got.b, got.c, e.kind, e.a, e.b, e.c);
         end
      end
   endtask

   // Monitor: turns DUT activity into events and checks them against the queue
   int  d_w = 0, q_w = 0, since_fall = 0;
   bit  prev_fault = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         d_w = 0; q_w = 0; since_fall = 0; prev_fault = 1'b0;
      end else begin
         since_fall++;
         if (eject_dollar && eject_quarter) check("both_eject", 1, 0);
         if (eject_dollar) d_w++;
         else if (d_w != 0) begin match(mk(K_D, d_w, 0, 0)); d_w = 0; since_fall = 0; end
         if (eject_quarter) q_w++;
         else if (q_w != 0) begin match(mk(K_Q, q_w, 0, 0)); q_w = 0; since_fall = 0; end
         if (done) match(mk(K_DONE, int'(remaining), int'(paid_total), 0));
         if (fault && !prev_fault) match(mk(K_FAULT, int'(remaining), int'(paid_total), since_fall));
         prev_fault = fault;
      end
   end

   // Hopper model: a coin drops out 3 cycles after each pulse ends
   initial begin
      bit prev_ej;
      prev_ej = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_en && prev_ej && !(eject_dollar || eject_quarter)) begin
            repeat (3) @(negedge clk);
            coin_sensed = 1'b1;
            @(negedge clk);
            coin_sensed = 1'b0;
         end
         prev_ej = eject_dollar || eject_quarter;
      end
   end

   task automatic issue(input int bal);
      @(negedge clk);
      balance    = 12'(bal);
      refund_req = 1'b1;
      @(negedge clk);
      check("busy_rise", int'(busy), 1);
      refund_req = 1'b0;
   endtask

   task automatic push_payout(input int nd, input int nq, input int rem, input int paid);
      for (int i = 0; i < nd; i++) exp_q.push_back(mk(K_D, PW, 0, 0));
      for (int i = 0; i < nq; i++) exp_q.push_back(mk(K_Q, PW, 0, 0));
      exp_q.push_back(mk(K_DONE, rem, paid, 0));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || busy) && n < budget);
      check({name, "_complete"}, int'(exp_q.size() == 0 && !busy), 1);
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_eject_dollar"}, int'(eject_dollar), 0);
      check({name, "_eject_quarter"}, int'(eject_quarter), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_done"}, int'(done), 0);
      check({name, "_fault"}, int'(fault), 0);
      check({name, "_remaining"}, int'(remaining), 0);
      check({name, "_paid"}, int'(paid_total), 0);
   endtask

   int vb[5] = '{225, 130, 20, 25, 4095};
   int vd[5] = '{2, 1, 0, 0, 40};
   int vq[5] = '{1, 1, 0, 1, 3};
   int vr[5] = '{0, 5, 20, 0, 20};

   initial begin
      int n;
      #5;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
`ifdef COIN_INVENTORY_EN
      @(negedge clk); reload = 1'b1;
      @(negedge clk); reload = 1'b0;
`endif
      ack_en = 1'b1;

      // Directed payouts, largest coin first, residual kept
      for (int i = 0; i < 5; i++) begin
         push_payout(vd[i], vq[i], vr[i], vb[i] - vr[i]);
         issue(vb[i]);
         if (i == 1) begin
            // a sensor pulse during the eject pulse must not count
            n = 0;
            while (!eject_dollar && n < 20) begin @(negedge clk); n++; end
            coin_sensed = 1'b1;
            @(negedge clk);
            coin_sensed = 1'b0;
         end
         wait_idle("payout", 2000);
         if (i == 1) begin
            // sensor pulse in IDLE is ignored and results hold
            coin_sensed = 1'b1;
            @(negedge clk);
            coin_sensed = 1'b0;
            repeat (2) @(negedge clk);
            check("idle_coin_remaining", int'(remaining), 5);
            check("idle_coin_paid", int'(paid_total), 125);
         end
      end

      // Missing acknowledgement: fault after the timeout, then resume
      ack_en = 1'b0;
      exp_q.push_back(mk(K_D, PW, 0, 0));
      exp_q.push_back(mk(K_FAULT, 100, 0, AT));
      issue(100);
      n = 0;
      while (!fault && n < 400) begin @(negedge clk); n++; end
      check("fault_reached", int'(fault), 1);
      issue(25);  // ignored while faulted
      check("fault_held_remaining", int'(remaining), 100);
      ack_en = 1'b1;
      push_payout(1, 0, 0, 100);
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
      wait_idle("fault_resume", 200);

      // Reset during the second dollar pulse of a 200 payout
      exp_q.push_back(mk(K_D, PW, 0, 0));
      issue(200);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      check("rst_first_pulse", exp_q.size(), 0);
      balance = 12'd25;
      refund_req = 1'b1;  // edge while busy, ignored
      @(negedge clk);
      refund_req = 1'b0;
      n = 0;
      while (!eject_dollar && n < 100) begin @(negedge clk); n++; end
      check("rst_second_pulse_seen", int'(eject_dollar), 1);
      @(negedge clk);
      check("rst_mid_remaining", int'(remaining), 100);
      ack_en = 1'b0;
      #2 reset = 1'b0;
      #1 check_all_zero("rst_async");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check_all_zero("rst_release");
      check("rst_queue", exp_q.size(), 0);

`ifdef COIN_INVENTORY_EN
      // Inventory: drain dollars, then a dollar-sized payout uses quarters
      ack_en = 1'b1;
      @(negedge clk); reload = 1'b1;
      @(negedge clk); reload = 1'b0;
      check("inv_reload_d", int'(dollar_cnt), 200);
      check("inv_reload_q", int'(quarter_cnt), 200);
      check("inv_low_after_reload", int'(low_coin), 0);
      for (int i = 0; i < 200; i++) begin
         push_payout(1, 0, 0, 100);
         issue(100);
         wait_idle("inv_drain", 100);
      end
      check("inv_dollar_empty", int'(dollar_cnt), 0);
      check("inv_low_coin", int'(low_coin), 1);
      push_payout(0, 4, 0, 100);
      issue(100);
      wait_idle("inv_quarters", 200);
      check("inv_quarter_cnt", int'(quarter_cnt), 196);
`endif

      check("final_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameters SHALL be: PULSE_W, 4, cycles each eject pulse is held high (1..15).
REQ-002 Parameters SHALL be: ACK_TIMEOUT, 255, cycles to wait for coin_sensed after pulse end (1..255).
REQ-003 Ports SHALL be: clk  in  1  single clock, 50MHz; all logic on posedge.
REQ-004 Ports SHALL be: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports SHALL be: refund_req  in  1  request to pay out balance; rising edge acts.
REQ-006 Ports SHALL be: balance  in  12  credit in cents, sampled on accepted refund_req.
REQ-007 Ports SHALL be: coin_sensed  in  1  hopper exit sensor, one-cycle pulse per coin ejected.
REQ-008 Ports SHALL be: fault_clr  in  1  clears FAULT state.
REQ-009 Ports SHALL be: eject_dollar  out  1  dollar hopper drive pulse.
REQ-010 Ports SHALL be: eject_quarter  out  1  quarter hopper drive pulse.
REQ-011 Ports SHALL be: busy  out  1  high in any state except IDLE.
REQ-012 Ports SHALL be: done  out  1  one-cycle pulse at payout completion.
REQ-013 Ports SHALL be: fault  out  1  high while in FAULT.
REQ-014 Ports SHALL be: remaining  out  12  cents still owed.
REQ-015 Ports SHALL be: paid_total  out  12  cents paid in current/last payout.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
REQ-017 IDLE: on refund_req 0->1 (registered edge detect), SHALL latch remaining<=balance, paid_total<=0, go SELECT; busy rises next cycle.
REQ-018 refund_req edges outside IDLE SHALL be ignored, not queued.
REQ-019 SELECT: remaining>=100 and dollar usable -> EJECT(dollar); else remaining>=25 and quarter usable -> EJECT(quarter); else remaining>=25 -> FAULT; else -> DONE.
REQ-020 EJECT: selected eject output SHALL be high exactly PULSE_W cycles, other eject output low; then WAIT_ACK.
REQ-021 Both eject outputs SHALL never be high in the same cycle.
REQ-022 WAIT_ACK: on coin_sensed, remaining SHALL decrease and paid_total increase by coin value (100 or 25) in the same update; go SELECT.
REQ-023 WAIT_ACK: ACK_TIMEOUT cycles with no coin_sensed SHALL go FAULT; remaining, paid_total held.
REQ-024 coin_sensed in any state other than WAIT_ACK SHALL be ignored; coin_sensed during EJECT SHALL be ignored.
REQ-025 Subtraction SHALL occur only when remaining>=coin value; remaining never wraps below 0.
REQ-026 Residual below 25 (balance not multiple of 25) SHALL stay in remaining at DONE.
REQ-027 DONE: done high one cycle, then IDLE; remaining, paid_total hold until next accepted request.
REQ-028 FAULT: fault high; on fault_clr high SHALL go SELECT, resuming payout of remaining.
REQ-029 Without COIN_INVENTORY_EN, both coin types SHALL always be usable.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, eject_dollar=0, eject_quarter=0, busy=0, done=0, fault=0, remaining=0, paid_total=0, counters 0.
REQ-031 reset asserted mid-payout SHALL abort immediately; no eject pulse continues, no resumption after release.

Configuration
REQ-032 Macro COIN_INVENTORY_EN SHALL, when defined, add ports reload (in 1), dollar_cnt (out 8), quarter_cnt (out 8), low_coin (out 1).
REQ-033 With COIN_INVENTORY_EN: reload high SHALL set both counts to 200 (reload ignored while busy); each accepted coin_sensed SHALL decrement its count; a type is usable only if its count>0; low_coin=1 when either count<10; counts reset to 0.
REQ-034 Without COIN_INVENTORY_EN: these ports and counters SHALL not exist; behaviour per REQ-029.

Verification
REQ-035 balance=225, refund_req, ack each pulse after 3 cycles -> dollar, dollar, quarter pulses of 4 cycles; done; remaining=0, paid_total=225.
REQ-036 balance=130 -> one dollar, one quarter; done; remaining=5.
REQ-037 balance=100, no coin_sensed -> FAULT after 255 cycles, remaining=100; fault_clr then ack -> done, paid_total=100.
REQ-038 reset low during second eject pulse of 200 payout -> all outputs 0 same cycle; IDLE after release; refund_req while busy ignored.
REQ-039 COIN_INVENTORY_EN, reload, dollar_cnt forced to 0 by 200 payouts, balance=100 -> four quarter pulses; quarter_cnt decrements 4.
